// File: rtl/bp_cce_hybrid_cmd_merge_if.sv
// One BedRock Burst LCE command stream: header channel plus data-beat channel, ready&valid on each.
interface bp_cce_hybrid_cmd_merge_if
  #(parameter int unsigned header_width_p   = 64
   ,parameter int unsigned lce_data_width_p = 64
   );

   logic [header_width_p-1:0]   header;
   logic                        header_v;
   logic                        header_ready_and;
   logic                        has_data;
   logic [lce_data_width_p-1:0] data;
   logic                        data_v;
   logic                        data_ready_and;
   logic                        last;

   modport master (output header, header_v, has_data, data, data_v, last,
                   input  header_ready_and, data_ready_and);

   modport slave  (input  header, header_v, has_data, data, data_v, last,
                   output header_ready_and, data_ready_and);

endinterface

// File: rtl/bp_cce_hybrid_cmd_merge.sv
// Merges the cacheable and uncached CCE LCE command streams into one burst stream; the header grant is held to the last beat.
// BP_CCE_HYBRID_CMD_MERGE_FIXED_PRIO_EN: cacheable pipe always wins a tie instead of round-robin.
module bp_cce_hybrid_cmd_merge
  #(parameter int unsigned max_burst_beats_p = 8)
   (input  logic                              clk_i
   ,input  logic                              reset_n_i
   ,input  logic                              stall_i
   ,output logic                              empty_o
   ,output logic                              error_o
   ,bp_cce_hybrid_cmd_merge_if.slave          lce_cmd_i
   ,bp_cce_hybrid_cmd_merge_if.slave          uc_lce_cmd_i
   ,bp_cce_hybrid_cmd_merge_if.master         lce_cmd_o
   );

   localparam int unsigned cnt_width_lp = $clog2(max_burst_beats_p + 1);

   typedef enum logic {e_idle, e_data} state_e;

   state_e                  state_r;
   logic                    lock_r;
   logic                    grant_r;
   logic                    error_r;
   logic [cnt_width_lp-1:0] beat_cnt_r;
`ifdef BP_CCE_HYBRID_CMD_MERGE_FIXED_PRIO_EN
`else
   logic                    rr_prio_r;
`endif

   logic sel;
   logic hdr_v;
   logic in_data;
   logic hdr_fire;
   logic data_fire;

   always_comb begin
      sel   = grant_r;
      hdr_v = 1'b0;
      if (reset_n_i && (state_r == e_idle)) begin
         // A pending offer stays pinned to its source even under stall_i.
         if (lock_r) begin
            sel   = grant_r;
            hdr_v = grant_r ? uc_lce_cmd_i.header_v : lce_cmd_i.header_v;
         end else if (!stall_i) begin
            case ({uc_lce_cmd_i.header_v, lce_cmd_i.header_v})
`ifdef BP_CCE_HYBRID_CMD_MERGE_FIXED_PRIO_EN
               2'b11:   sel = 1'b0;
`else
               2'b11:   sel = rr_prio_r;
`endif
               2'b10:   sel = 1'b1;
               2'b01:   sel = 1'b0;
               default: sel = grant_r;
            endcase
            hdr_v = lce_cmd_i.header_v | uc_lce_cmd_i.header_v;
         end
      end

      lce_cmd_o.header             = sel ? uc_lce_cmd_i.header   : lce_cmd_i.header;
      lce_cmd_o.has_data           = sel ? uc_lce_cmd_i.has_data : lce_cmd_i.has_data;
      lce_cmd_o.header_v           = hdr_v;
      lce_cmd_i.header_ready_and    = hdr_v & ~sel & lce_cmd_o.header_ready_and;
      uc_lce_cmd_i.header_ready_and = hdr_v &  sel & lce_cmd_o.header_ready_and;

      in_data                      = reset_n_i & (state_r == e_data);
      lce_cmd_o.data               = grant_r ? uc_lce_cmd_i.data : lce_cmd_i.data;
      lce_cmd_o.last               = grant_r ? uc_lce_cmd_i.last : lce_cmd_i.last;
      lce_cmd_o.data_v             = in_data & (grant_r ? uc_lce_cmd_i.data_v : lce_cmd_i.data_v);
      lce_cmd_i.data_ready_and      = in_data & ~grant_r & lce_cmd_o.data_ready_and;
      uc_lce_cmd_i.data_ready_and   = in_data &  grant_r & lce_cmd_o.data_ready_and;

      hdr_fire  = hdr_v & lce_cmd_o.header_ready_and;
      data_fire = lce_cmd_o.data_v & lce_cmd_o.data_ready_and;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r    <= e_idle;
         lock_r     <= 1'b0;
         grant_r    <= 1'b0;
         error_r    <= 1'b0;
         beat_cnt_r <= '0;
`ifdef BP_CCE_HYBRID_CMD_MERGE_FIXED_PRIO_EN
`else
         rr_prio_r  <= 1'b0;
`endif
      end else begin
         case (state_r)
            e_idle: begin
               if (hdr_v) begin
                  grant_r <= sel;
                  if (hdr_fire) begin
                     lock_r <= 1'b0;
`ifdef BP_CCE_HYBRID_CMD_MERGE_FIXED_PRIO_EN
`else
                     rr_prio_r <= ~sel;
`endif
                     if (lce_cmd_o.has_data) begin
                        state_r    <= e_data;
                        beat_cnt_r <= '0;
                     end
                  end else begin
                     lock_r <= 1'b1;
                  end
               end
            end
            e_data: begin
               if (data_fire) begin
                  if (beat_cnt_r != cnt_width_lp'(max_burst_beats_p))
                     beat_cnt_r <= beat_cnt_r + 1'b1;
                  if (!lce_cmd_o.last && (beat_cnt_r == cnt_width_lp'(max_burst_beats_p - 1)))
                     error_r <= 1'b1;
                  if (lce_cmd_o.last)
                     state_r <= e_idle;
               end
            end
            default: state_r <= e_idle;
         endcase
      end
   end

   assign empty_o = (state_r == e_idle) & ~lock_r;
   assign error_o = error_r;

endmodule

// File: tb/tb_bp_cce_hybrid_cmd_merge.sv
// Bench for bp_cce_hybrid_cmd_merge: message-level scoreboard of expected output order plus directed literal checks.
module tb_bp_cce_hybrid_cmd_merge;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic stall = 1'b0;
   logic empty, err;
   logic out_hr = 1'b0;
   logic out_dr = 1'b0;

   always #5 clk = ~clk;

   bp_cce_hybrid_cmd_merge_if #(.header_width_p(32), .lce_data_width_p(64)) c_if ();
   bp_cce_hybrid_cmd_merge_if #(.header_width_p(32), .lce_data_width_p(64)) u_if ();
   bp_cce_hybrid_cmd_merge_if #(.header_width_p(32), .lce_data_width_p(64)) o_if ();

   bp_cce_hybrid_cmd_merge #(.max_burst_beats_p(8)) dut
     (.clk_i(clk), .reset_n_i(rst_n), .stall_i(stall), .empty_o(empty), .error_o(err),
      .lce_cmd_i(c_if), .uc_lce_cmd_i(u_if), .lce_cmd_o(o_if));

   typedef struct {
      int unsigned src;
      logic [31:0] hdr;
      bit          has_data;
      int unsigned nbeats;
   } msg_t;

   msg_t        src_q0[$], src_q1[$], exp_q[$];
   logic [64:0] beat_q[$];
   int          checks = 0;
   int          passed = 0;

   logic        s_hv[2], s_hd[2], s_dv[2], s_last[2];
   logic [31:0] s_hdr[2];
   logic [63:0] s_data[2];

   assign c_if.header   = s_hdr[0];
   assign c_if.header_v = s_hv[0];
   assign c_if.has_data = s_hd[0];
   assign c_if.data     = s_data[0];
   assign c_if.data_v   = s_dv[0];
   assign c_if.last     = s_last[0];
   assign u_if.header   = s_hdr[1];
   assign u_if.header_v = s_hv[1];
   assign u_if.has_data = s_hd[1];
   assign u_if.data     = s_data[1];
   assign u_if.data_v   = s_dv[1];
   assign u_if.last     = s_last[1];
   assign o_if.header_ready_and = out_hr;
   assign o_if.data_ready_and   = out_dr;

   function automatic logic [63:0] beat_val(logic [31:0] h, int unsigned i);
      return {h, i};
   endfunction

   function automatic msg_t mk(int unsigned s, logic [31:0] h, bit hd, int unsigned n);
      msg_t m;
      m.src = s; m.hdr = h; m.has_data = hd; m.nbeats = n;
      return m;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(msg_t m);
      if (m.src == 0) src_q0.push_back(m);
      else            src_q1.push_back(m);
   endtask

   task automatic drain(string name);
      int n = 0;
      while ((src_q0.size() + src_q1.size() + exp_q.size() + beat_q.size()) != 0 && n < 200) begin
         tick();
         n++;
      end
      check({name, "_drained"}, 64'(n < 200), 64'(1));
      tick();
      @(negedge clk);
      check({name, "_empty"}, 64'(empty), 64'(1));
   endtask

   // Source drivers: each pipe presents its header, then its beats, one message at a time.
   initial begin
      int unsigned phase[2];
      int unsigned bi[2];
      msg_t        cur[2];
      bit          fh[2], fd[2];
      for (int s = 0; s < 2; s++) begin
         phase[s] = 0; bi[s] = 0; cur[s] = mk(0, '0, 0, 0);
         s_hv[s] = 0; s_hd[s] = 0; s_dv[s] = 0; s_last[s] = 0; s_hdr[s] = '0; s_data[s] = '0;
      end
      forever begin
         @(negedge clk);
         fh[0] = s_hv[0] & c_if.header_ready_and;
         fd[0] = s_dv[0] & c_if.data_ready_and;
         fh[1] = s_hv[1] & u_if.header_ready_and;
         fd[1] = s_dv[1] & u_if.data_ready_and;
         @(posedge clk);
         #2;
         for (int s = 0; s < 2; s++) begin
            if (!rst_n) phase[s] = 0;
            else if (phase[s] == 1 && fh[s]) begin
               phase[s] = cur[s].has_data ? 2 : 0;
               bi[s] = 0;
            end else if (phase[s] == 2 && fd[s]) begin
               bi[s]++;
               if (bi[s] == cur[s].nbeats) phase[s] = 0;
            end
            if (rst_n && phase[s] == 0) begin
               if (s == 0 && src_q0.size() > 0) begin cur[0] = src_q0.pop_front(); phase[0] = 1; end
               if (s == 1 && src_q1.size() > 0) begin cur[1] = src_q1.pop_front(); phase[1] = 1; end
            end
            s_hv[s]   = (phase[s] == 1);
            s_hd[s]   = cur[s].has_data;
            s_hdr[s]  = cur[s].hdr;
            s_dv[s]   = (phase[s] == 2);
            s_data[s] = beat_val(cur[s].hdr, bi[s]);
            s_last[s] = (bi[s] + 1 == cur[s].nbeats);
         end
      end
   end

   // Scoreboard: the offered header is always the next one to be accepted, and bursts never interleave.
   initial begin
      int unsigned bsrc;
      logic [1:0]  exp_hr, exp_dr;
      msg_t        m;
      bsrc = 0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            exp_hr = 2'b00;
            if (o_if.header_v && out_hr && exp_q.size() > 0)
               exp_hr = (exp_q[0].src == 0) ? 2'b01 : 2'b10;
            check("hdr_ready_route", 64'({u_if.header_ready_and, c_if.header_ready_and}), 64'(exp_hr));
            exp_dr = 2'b00;
            if (beat_q.size() > 0 && out_dr)
               exp_dr = (bsrc == 0) ? 2'b01 : 2'b10;
            check("data_ready_route", 64'({u_if.data_ready_and, c_if.data_ready_and}), 64'(exp_dr));
            if (beat_q.size() > 0)
               check("hdr_v_in_burst", 64'(o_if.header_v), 64'(0));
            if (o_if.data_v) begin
               if (beat_q.size() == 0)
                  check("data_without_hdr", 64'(o_if.data_v), 64'(0));
               else begin
                  check("data_beat", o_if.data, beat_q[0][63:0]);
                  check("data_last", 64'(o_if.last), 64'(beat_q[0][64]));
                  if (out_dr) void'(beat_q.pop_front());
               end
            end
            if (o_if.header_v) begin
               if (exp_q.size() == 0)
                  check("unexpected_hdr", 64'(o_if.header_v), 64'(0));
               else begin
                  check("hdr", 64'(o_if.header), 64'(exp_q[0].hdr));
                  check("has_data", 64'(o_if.has_data), 64'(exp_q[0].has_data));
                  if (out_hr) begin
                     m = exp_q.pop_front();
                     bsrc = m.src;
                     if (m.has_data)
                        for (int unsigned i = 0; i < m.nbeats; i++)
                           beat_q.push_back({(i + 1 == m.nbeats), beat_val(m.hdr, i)});
                  end
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      bit c7, c8;
      // 1: reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_empty", 64'(empty), 64'(1));
      check("rst_error", 64'(err), 64'(0));
      check("rst_hdr_v", 64'(o_if.header_v), 64'(0));
      check("rst_data_v", 64'(o_if.data_v), 64'(0));
      check("rst_readies", 64'({c_if.header_ready_and, u_if.header_ready_and,
                                c_if.data_ready_and, u_if.data_ready_and}), 64'(0));
      tick();
      rst_n = 1'b1;
      tick();

      // 2: both pipes offer data-less headers
      out_hr = 1'b1; out_dr = 1'b1;
      send(mk(0, 32'hC1, 0, 0)); send(mk(0, 32'hC2, 0, 0));
      send(mk(1, 32'hA1, 0, 0)); send(mk(1, 32'hA2, 0, 0));
`ifdef BP_CCE_HYBRID_CMD_MERGE_FIXED_PRIO_EN
      exp_q.push_back(mk(0, 32'hC1, 0, 0)); exp_q.push_back(mk(0, 32'hC2, 0, 0));
      exp_q.push_back(mk(1, 32'hA1, 0, 0)); exp_q.push_back(mk(1, 32'hA2, 0, 0));
`else
      exp_q.push_back(mk(0, 32'hC1, 0, 0)); exp_q.push_back(mk(1, 32'hA1, 0, 0));
      exp_q.push_back(mk(0, 32'hC2, 0, 0)); exp_q.push_back(mk(1, 32'hA2, 0, 0));
`endif
      drain("t2");

      // 3: uncached burst, cacheable header arrives mid-burst
      tick();
      send(mk(1, 32'hA3, 1, 2));
      exp_q.push_back(mk(1, 32'hA3, 1, 2));
      n = 0;
      do begin @(negedge clk); n++; end while (!o_if.data_v && n < 20);
      check("t3_burst_started", 64'(o_if.data_v), 64'(1));
      tick();
      send(mk(0, 32'hC3, 0, 0));
      exp_q.push_back(mk(0, 32'hC3, 0, 0));
      drain("t3");

      // 4: unaccepted cacheable offer stays locked while uncached arrives
      out_hr = 1'b0;
      send(mk(0, 32'hC4, 0, 0));
      exp_q.push_back(mk(0, 32'hC4, 0, 0));
      exp_q.push_back(mk(1, 32'hA4, 0, 0));
      @(negedge clk);
      check("t4_first_offer", 64'(o_if.header), 64'(32'hC4));
      tick();
      send(mk(1, 32'hA4, 0, 0));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t4_held_hdr", 64'(o_if.header), 64'(32'hC4));
         check("t4_locked", 64'(empty), 64'(0));
         tick();
      end
      out_hr = 1'b1;
      drain("t4");

      // 5: stall completes a locked offer, then blocks new arbitration
      out_hr = 1'b0;
      send(mk(0, 32'hC5, 0, 0));
      exp_q.push_back(mk(0, 32'hC5, 0, 0));
      exp_q.push_back(mk(1, 32'hA5, 0, 0));
      @(negedge clk);
      check("t5_offer", 64'(o_if.header_v), 64'(1));
      tick();
      stall = 1'b1; out_hr = 1'b1;
      @(negedge clk);
      check("t5_locked_v", 64'(o_if.header_v), 64'(1));
      check("t5_locked_hdr", 64'(o_if.header), 64'(32'hC5));
      tick();
      send(mk(1, 32'hA5, 0, 0));
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("t5_stall_v", 64'(o_if.header_v), 64'(0));
         check("t5_stall_ready", 64'(u_if.header_ready_and), 64'(0));
         check("t5_stall_empty", 64'(empty), 64'(1));
         tick();
      end
      stall = 1'b0;
      drain("t5");
      check("t5_no_error", 64'(err), 64'(0));

      // 6: 9-beat burst overruns the 8-beat limit
      send(mk(0, 32'hC6, 1, 9));
      exp_q.push_back(mk(0, 32'hC6, 1, 9));
      n = 0; c7 = 0; c8 = 0;
      for (int cyc = 0; cyc < 100 && n < 9; cyc++) begin
         @(negedge clk);
         if (n == 7 && !c7) begin check("t6_err_before_8", 64'(err), 64'(0)); c7 = 1; end
         if (n == 8 && !c8) begin check("t6_err_after_8", 64'(err), 64'(1)); c8 = 1; end
         if (o_if.data_v && out_dr) n++;
      end
      check("t6_beats", 64'(n), 64'(9));
      tick();
      @(negedge clk);
      check("t6_idle", 64'(empty), 64'(1));
      check("t6_err_sticky", 64'(err), 64'(1));
      drain("t6");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
